morse_encoder_gen: RTL
======================

MORSE_ENCODER_GEN -- requirements
Module: morse_encoder_gen

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, input clock rate in Hz.
REQ-002 SHALL have parameter UNIT_DIV, default 2; one Morse unit = CLOCK_FREQUENCY/UNIT_DIV cycles (UNIT); UNIT >= 2.
REQ-003 SHALL have parameter CODE_WIDTH, default 16, width of the pattern register; legal values >= 13.
REQ-004 SHALL have port ClockIn  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Start  input  1  request to transmit Letter.
REQ-007 SHALL have port Letter  input  5  0..25 = A..Z; 26..31 invalid.
REQ-008 SHALL have port DotDashOut  output  1  current Morse symbol bit (1 = tone).
REQ-009 SHALL have port NewBitOut  output  1  one-cycle pulse on the first cycle of each presented bit.
REQ-010 SHALL have port Busy  output  1  high while a letter is in progress.
REQ-011 SHALL have port Done  output  1  one-cycle pulse when a letter completes.

Function
REQ-012 SHALL encode dot as "1", dash as "111", intra-letter gap as "0", MSB first, no trailing zero (A = 10111, length 5; Z = 1110111010101, length 13; E = 1, length 1).
REQ-013 SHALL hold a ROM of 26 entries: a CODE_WIDTH-bit left-justified pattern plus a length field of $clog2(CODE_WIDTH+1) bits.
REQ-014 SHALL implement states IDLE, SEND, GAP; GAP reachable only when MORSE_GAP_EN is defined.
REQ-015 SHALL, in IDLE with Start=1 and Letter<=25, latch pattern and length and enter SEND on that edge.
REQ-016 SHALL ignore Start in IDLE when Letter>=26: no state change, Busy, DotDashOut and Done remain 0.
REQ-017 SHALL ignore Start and Letter changes while Busy=1.
REQ-018 SHALL, on the cycle after acceptance, drive Busy=1, DotDashOut = pattern bit 0 (MSB), NewBitOut=1.
REQ-019 SHALL hold each bit for exactly UNIT cycles, with NewBitOut high only on the first of those cycles.
REQ-020 SHALL use a unit counter of $clog2(UNIT) bits wrapping UNIT-1 -> 0; the wrap advances to the next bit.
REQ-021 SHALL, after the last bit's UNIT cycles, drive DotDashOut=0, Busy=0, Done=1 for one cycle and return to IDLE (without MORSE_GAP_EN).
REQ-022 SHALL allow a new Start on the Done cycle; it is accepted normally (back-to-back letters).
REQ-023 SHALL keep NewBitOut, DotDashOut and Done at 0 whenever Busy=0, except Done during its pulse.

Reset
REQ-024 SHALL, with Reset=1 at a rising edge, enter IDLE and clear counter, pattern, length, DotDashOut, NewBitOut, Busy, Done to 0 on that edge.
REQ-025 SHALL abort any letter in progress on Reset with no Done pulse; Reset has priority over Start.
REQ-026 SHALL accept a Start in the first cycle after Reset deasserts.

Configuration
REQ-027 SHALL support macro MORSE_GAP_EN.
REQ-028 SHALL, with MORSE_GAP_EN defined, enter GAP after the last bit, hold DotDashOut=0, Busy=1, NewBitOut=0 for 3*UNIT cycles, then pulse Done and return to IDLE.
REQ-029 SHALL, without MORSE_GAP_EN, omit the GAP state and its counter entirely (REQ-021 timing).

Verification (CLOCK_FREQUENCY=8, UNIT_DIV=2, UNIT=4; Start accepted at edge of cycle 0)
REQ-030 SHALL verify: Reset held 2 cycles -> all outputs 0; Busy stays 0 with Start=0.
REQ-031 SHALL verify: Letter=0 (A) -> DotDashOut 1,0,1,1,1 each 4 cycles over cycles 1..20; NewBitOut at 1,5,9,13,17; Done at 21; Busy 1..20.
REQ-032 SHALL verify: Letter=4 (E) -> DotDashOut=1 cycles 1..4; Done at 5; Start with Letter=25 (Z) at 5 -> Z starts at cycle 6.
REQ-033 SHALL verify: Start with Letter=27 -> Busy, DotDashOut, Done remain 0 for 30 cycles.
REQ-034 SHALL verify: Start Letter=16 (Q) mid-letter at cycle 6 and Reset at cycle 10 -> Q ignored; all outputs 0 from cycle 11; no Done; a new Start then transmits from bit 0.
REQ-035 SHALL verify (MORSE_GAP_EN): Letter=0 -> bits as REQ-031, DotDashOut=0 and Busy=1 cycles 21..32, Done at 33.

Source files
------------

// File: rtl/morse_encoder_gen.sv
// Morse letter encoder: streams the on/off keying pattern of one letter A..Z, one bit per Morse unit.
// Optional MORSE_GAP_EN appends a 3-unit silent inter-letter gap before the Done pulse.
module morse_encoder_gen #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UNIT_DIV        = 2,
    parameter int CODE_WIDTH      = 16
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Letter,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done
);
    localparam int UNIT  = CLOCK_FREQUENCY / UNIT_DIV;
    localparam int CNT_W = $clog2(UNIT);
    localparam int LEN_W = $clog2(CODE_WIDTH + 1);
    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT - 1);
`ifdef MORSE_GAP_EN
    localparam int GAP_W = $clog2(3 * UNIT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(3 * UNIT - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef MORSE_GAP_EN
        , GAP
`endif
    } state_t;

    state_t               state_p0;
    state_t               state_nxt;
    logic [CNT_W-1:0]     unit_cnt_p0;
    logic [CODE_WIDTH-1:0] pattern_p0;
    logic [LEN_W-1:0]     len_p0;
    logic                 done_p0;
    logic                 load;
    logic                 finish;
    logic                 unit_wrap;
`ifdef MORSE_GAP_EN
    logic [GAP_W-1:0]     gap_cnt_p0;
`endif

    // ROM entry: {length[3:0], pattern right-aligned in 13 bits}
    function automatic logic [16:0] rom_raw(input logic [4:0] l);
        case (l)
            5'd0:  rom_raw = {4'd5,  13'b0000000010111};
            5'd1:  rom_raw = {4'd9,  13'b0000111010101};
            5'd2:  rom_raw = {4'd11, 13'b0011101011101};
            5'd3:  rom_raw = {4'd7,  13'b0000001110101};
            5'd4:  rom_raw = {4'd1,  13'b0000000000001};
            5'd5:  rom_raw = {4'd9,  13'b0000101011101};
            5'd6:  rom_raw = {4'd9,  13'b0000111011101};
            5'd7:  rom_raw = {4'd7,  13'b0000001010101};
            5'd8:  rom_raw = {4'd3,  13'b0000000000101};
            5'd9:  rom_raw = {4'd13, 13'b1011101110111};
            5'd10: rom_raw = {4'd9,  13'b0000111010111};
            5'd11: rom_raw = {4'd9,  13'b0000101110101};
            5'd12: rom_raw = {4'd7,  13'b0000001110111};
            5'd13: rom_raw = {4'd5,  13'b0000000011101};
            5'd14: rom_raw = {4'd11, 13'b0011101110111};
            5'd15: rom_raw = {4'd11, 13'b0010111011101};
            5'd16: rom_raw = {4'd13, 13'b1110111010111};
            5'd17: rom_raw = {4'd7,  13'b0000001011101};
            5'd18: rom_raw = {4'd5,  13'b0000000010101};
            5'd19: rom_raw = {4'd3,  13'b0000000000111};
            5'd20: rom_raw = {4'd7,  13'b0000001010111};
            5'd21: rom_raw = {4'd9,  13'b0000101010111};
            5'd22: rom_raw = {4'd9,  13'b0000101110111};
            5'd23: rom_raw = {4'd11, 13'b0011101010111};
            5'd24: rom_raw = {4'd13, 13'b1110101110111};
            5'd25: rom_raw = {4'd13, 13'b1110111010101};
            default: rom_raw = 17'd0;
        endcase
    endfunction

    // Left-justify so the first transmitted bit sits in the MSB of the pattern register
    function automatic logic [CODE_WIDTH-1:0] rom_pattern(input logic [4:0] l);
        logic [16:0]           raw;
        logic [CODE_WIDTH-1:0] w;
        raw = rom_raw(l);
        w = CODE_WIDTH'(raw[12:0]);
        w = w << (CODE_WIDTH - int'(raw[16:13]));
        return w;
    endfunction

    function automatic logic [LEN_W-1:0] rom_length(input logic [4:0] l);
        logic [16:0] raw;
        raw = rom_raw(l);
        return LEN_W'(raw[16:13]);
    endfunction

    assign unit_wrap = (unit_cnt_p0 == UNIT_LAST);

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        load      = 1'b0;
        finish    = 1'b0;
        case (state_p0)
            IDLE: begin
                if (Start && (Letter <= 5'd25)) begin
                    state_nxt = SEND;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (unit_wrap && (len_p0 == LEN_W'(1))) begin
`ifdef MORSE_GAP_EN
                    state_nxt = GAP;
`else
                    state_nxt = IDLE;
                    finish    = 1'b1;
`endif
                end
            end
`ifdef MORSE_GAP_EN
            GAP: begin
                if (gap_cnt_p0 == GAP_LAST) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: bit timing, pattern shift and completion flag
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            unit_cnt_p0 <= '0;
            pattern_p0  <= '0;
            len_p0      <= '0;
            done_p0     <= 1'b0;
        end else begin
            done_p0 <= finish;
            if (load) begin
                unit_cnt_p0 <= '0;
                pattern_p0  <= rom_pattern(Letter);
                len_p0      <= rom_length(Letter);
            end else if (state_p0 == SEND) begin
                unit_cnt_p0 <= unit_wrap ? '0 : unit_cnt_p0 + CNT_W'(1);
                if (unit_wrap) begin
                    pattern_p0 <= pattern_p0 << 1;
                    len_p0     <= len_p0 - LEN_W'(1);
                end
            end
        end
    end

`ifdef MORSE_GAP_EN
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            gap_cnt_p0 <= '0;
        end else if (state_p0 == GAP) begin
            gap_cnt_p0 <= gap_cnt_p0 + GAP_W'(1);
        end else begin
            gap_cnt_p0 <= '0;
        end
    end
`endif

    assign Busy       = (state_p0 != IDLE);
    assign DotDashOut = (state_p0 == SEND) && pattern_p0[CODE_WIDTH-1];
    assign NewBitOut  = (state_p0 == SEND) && (unit_cnt_p0 == '0);
    assign Done       = done_p0;

endmodule
